// File: rtl/dm_pkg.sv
// +--------------------------------------------------------------------+
// | dm_pkg : shared encodings for the multi-cycle data memory          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dm_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] FLT_NONE  = 2'd0;
    localparam logic [1:0] FLT_LOAD  = 2'd1;
    localparam logic [1:0] FLT_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dm_lane.sv
// +--------------------------------------------------------------------+
// | dm_lane : store byte-enables/replication, load extract/extend      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = word[8*byte_off +: 8];
    assign sel_half = byte_off[1] ? word[31:16] : word[15:0];

    always_comb begin
        be    = 4'b1111;
        wrep  = wdata;
        rdata = word;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << byte_off;
                wrep  = {4{wdata[7:0]}};
                rdata = {{24{is_signed & sel_byte[7]}}, sel_byte};
            end
            SZ_H: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
                rdata = {{16{is_signed & sel_half[15]}}, sel_half};
            end
            default: begin
                be    = 4'b1111;
                wrep  = wdata;
                rdata = word;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_mc.sv
// +--------------------------------------------------------------------+
// | dm_mc : configurable-latency data memory with fault detection      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dm_mc
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic        busy
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        hold_we, hold_signed;
    logic [1:0]  hold_size;
    logic [31:0] hold_addr, hold_wdata, hold_pc;

    logic        accept, req_fault, commit, in_wait;
    logic [32:0] req_bytes, req_offs, req_end;
    logic        cmd_we, cmd_signed;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata, cmd_offs;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_word, wrep, lane_rdata;
    logic [3:0]  be;
    logic        unused_bits;

    assign in_wait   = (state == ST_WAIT);
    assign req_ready = (state == ST_IDLE || state == ST_RESP) && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = in_wait;

    always_comb begin
        req_bytes = 33'd1;
        case (req_size)
            SZ_H:    req_bytes = 33'd2;
            SZ_W:    req_bytes = 33'd4;
            default: req_bytes = 33'd1;
        endcase
    end

    // 33-bit offset: bit 32 is the borrow for addresses below BASE_ADDR
    assign req_offs  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign req_end   = req_offs + req_bytes;
    assign req_fault = (req_size == 2'd3)
                    || (req_size == SZ_H && req_addr[0])
                    || (req_size == SZ_W && req_addr[1:0] != 2'b00)
                    || req_offs[32]
                    || (req_end > SPAN);

    // Zero-wait requests commit straight from the request bus
    assign cmd_we     = in_wait ? hold_we     : req_we;
    assign cmd_size   = in_wait ? hold_size   : req_size;
    assign cmd_signed = in_wait ? hold_signed : req_signed;
    assign cmd_addr   = in_wait ? hold_addr   : req_addr;
    assign cmd_wdata  = in_wait ? hold_wdata  : req_wdata;
    assign cmd_offs   = cmd_addr - BASE_ADDR;
    assign idx        = cmd_offs[AW+1:2];
    assign mem_word   = mem[idx];

    assign commit = in_wait ? (!flush && cnt == 4'd0)
                            : (accept && !req_fault && WAIT_CYCLES == 0);

    assign unused_bits = ^{hold_pc, cmd_offs[31:AW+2], cmd_offs[1:0]};

    dm_lane u_lane (
        .size      (cmd_size),
        .is_signed (cmd_signed),
        .byte_off  (cmd_addr[1:0]),
        .wdata     (cmd_wdata),
        .word      (mem_word),
        .be        (be),
        .wrep      (wrep),
        .rdata     (lane_rdata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept)
                    state_nx = (req_fault || WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                else
                    state_nx = ST_IDLE;
            end
            ST_WAIT: begin
                if (flush)
                    state_nx = ST_IDLE;
                else if (cnt == 4'd0)
                    state_nx = ST_RESP;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            hold_we     <= 1'b0;
            hold_size   <= 2'd0;
            hold_signed <= 1'b0;
            hold_addr   <= 32'd0;
            hold_wdata  <= 32'd0;
            hold_pc     <= 32'd0;
            rsp_rdata   <= 32'd0;
            rsp_fault   <= FLT_NONE;
        end else begin
            state <= state_nx;
            if (accept) begin
                hold_we     <= req_we;
                hold_size   <= req_size;
                hold_signed <= req_signed;
                hold_addr   <= req_addr;
                hold_wdata  <= req_wdata;
                hold_pc     <= req_pc;
                if (!req_fault)
                    cnt <= WAIT_LOAD;
            end else if (in_wait && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (accept && req_fault) begin
                rsp_rdata <= 32'd0;
                rsp_fault <= req_we ? FLT_STORE : FLT_LOAD;
            end else if (commit) begin
                rsp_rdata <= cmd_we ? 32'd0 : lane_rdata;
                rsp_fault <= FLT_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'd0;
        end else if (commit && cmd_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= wrep[8*b +: 8];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_mc.sv
// +--------------------------------------------------------------------+
// | tb_dm_mc : scoreboard bench for dm_mc (WAIT=2 and WAIT=0 copies)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dm_mc;
    import dm_pkg::*;

    localparam int DEPTH = 256;
    localparam int WA    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_we = 0, a_signed = 0, a_flush = 0;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_pc = 0;
    logic        a_ready, a_rsp_valid, a_busy;
    logic [31:0] a_rdata;
    logic [1:0]  a_fault;

    logic        b_valid = 0, b_we = 0, b_signed = 0, b_flush = 0;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0, b_wdata = 0, b_pc = 0;
    logic        b_ready, b_rsp_valid, b_busy;
    logic [31:0] b_rdata;
    logic [1:0]  b_fault;

    dm_mc #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_size(a_size), .req_signed(a_signed), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_pc(a_pc), .flush(a_flush), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .rsp_fault(a_fault), .busy(a_busy)
    );

    dm_mc #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_pc(b_pc), .flush(b_flush), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .rsp_fault(b_fault), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          acc;
        int          lat;
        logic        tr;
        logic [31:0] pc;
        logic [31:0] waddr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   checks = 0, failures = 0;
    int   npc = 0;
    int   busy_a = 0;
    int   brun = 0, brun_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Latency is the number of rising edges from accept to the edge sampling rsp_valid
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_busy === 1'b1) busy_a++;
        if (!reset && a_rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_rsp: got rdata %h fault %0d, expected no response", a_rdata, a_fault);
            end else begin
                e = qa.pop_front();
                chk("a_rdata", a_rdata, e.rdata);
                chk("a_fault", {30'd0, a_fault}, {30'd0, e.fault});
                chk("a_latency", cyc + 1 - e.acc, e.lat);
                if (e.tr)
                    $display("@%h: *%h <= %h", e.pc, e.waddr, dut_a.mem[e.waddr >> 2]);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rsp_valid === 1'b1) brun++; else brun = 0;
        if (brun > brun_max) brun_max = brun;
        if (!reset && b_rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_rsp: got rdata %h fault %0d, expected no response", b_rdata, b_fault);
            end else begin
                e = qb.pop_front();
                chk("b_rdata", b_rdata, e.rdata);
                chk("b_fault", {30'd0, b_fault}, {30'd0, e.fault});
                chk("b_latency", cyc + 1 - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic want, input logic [31:0] er, input logic [1:0] ef);
        int   t;
        exp_t e;
        @(negedge clk);
        a_valid = 1; a_we = we; a_size = sz; a_signed = sg;
        a_addr = ad; a_wdata = wd; a_pc = 32'h1000 + 32'(npc * 4);
        npc++;
        t = 0;
        #1;
        while (a_ready !== 1'b1 && t < 40) begin
            @(negedge clk); #1; t++;
        end
        if (a_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL a_accept_timeout: got ready %b expected 1", a_ready);
            a_valid = 0;
            return;
        end
        @(posedge clk); #1;
        a_valid = 0;
        if (want) begin
            e.rdata = er; e.fault = ef; e.acc = cyc;
            e.lat = (ef != FLT_NONE) ? 1 : WA + 1;
            e.tr = we && (ef == FLT_NONE);
            e.pc = a_pc; e.waddr = {ad[31:2], 2'b00};
            qa.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 60) begin
            @(negedge clk); t++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", qa.size() + qb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        exp_t eb;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_a_ready", {31'd0, a_ready}, 32'd0);
        chk("reset_b_ready", {31'd0, b_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("reset_rdata", a_rdata, 32'd0);
        chk("reset_fault", {30'd0, a_fault}, 32'd0);
        chk("reset_busy", {31'd0, a_busy}, 32'd0);
        reset = 0;

        // Zero-wait copy: four stores then four loads with valid held high
        @(negedge clk);
        b_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_we = (i < 4); b_size = SZ_W; b_signed = 0;
            b_addr = 32'(32'h100 + 4 * (i % 4));
            b_wdata = (i < 4) ? 32'hA500_0000 + 32'(i) : 32'd0;
            b_pc = 32'h2000 + 32'(4 * i);
            #1;
            chk("b_ready", {31'd0, b_ready}, 32'd1);
            @(posedge clk); #1;
            eb.rdata = (i < 4) ? 32'd0 : 32'hA500_0000 + 32'(i - 4);
            eb.fault = FLT_NONE; eb.acc = cyc; eb.lat = 1;
            eb.tr = 0; eb.pc = b_pc; eb.waddr = b_addr;
            qb.push_back(eb);
            @(negedge clk);
        end
        b_valid = 0;
        drain();
        chk("b_rsp_run", brun_max, 8);

        busy_a = 0;
        issue(1, SZ_W, 0, 32'h10, 32'h1234_5678, 1, 32'd0, FLT_NONE);
        issue(0, SZ_W, 0, 32'h10, 32'd0, 1, 32'h1234_5678, FLT_NONE);
        drain();
        chk("a_busy_cycles", busy_a, 4);

        issue(1, SZ_W, 0, 32'h20, 32'd0,  1, 32'd0, FLT_NONE);
        issue(1, SZ_B, 0, 32'h21, 32'h80, 1, 32'd0, FLT_NONE);
        issue(0, SZ_B, 1, 32'h21, 32'd0,  1, 32'hFFFF_FF80, FLT_NONE);
        issue(0, SZ_B, 0, 32'h21, 32'd0,  1, 32'h0000_0080, FLT_NONE);
        issue(0, SZ_H, 1, 32'h20, 32'd0,  1, 32'hFFFF_8000, FLT_NONE);
        drain();

        issue(0, SZ_W, 0, 32'h2, 32'd0, 1, 32'd0, FLT_LOAD);
        issue(1, SZ_H, 0, 32'h3, 32'hBEEF, 1, 32'd0, FLT_STORE);
        issue(1, SZ_W, 0, 32'(4 * DEPTH), 32'hCAFE_F00D, 1, 32'd0, FLT_STORE);
        issue(0, 2'd3, 0, 32'h0, 32'd0, 1, 32'd0, FLT_LOAD);
        issue(0, SZ_B, 0, 32'(4 * DEPTH), 32'd0, 1, 32'd0, FLT_LOAD);
        issue(0, SZ_W, 0, 32'h0, 32'd0, 1, 32'd0, FLT_NONE);
        issue(0, SZ_W, 0, 32'(4 * DEPTH - 4), 32'd0, 1, 32'd0, FLT_NONE);
        issue(0, SZ_H, 0, 32'(4 * DEPTH - 2), 32'd0, 1, 32'd0, FLT_NONE);
        drain();

        // Flush during the second WAIT cycle kills the store
        issue(1, SZ_W, 0, 32'h40, 32'h0000_DEAD, 0, 32'd0, FLT_NONE);
        @(negedge clk);
        @(negedge clk);
        a_flush = 1;
        #1;
        chk("flush_ready", {31'd0, a_ready}, 32'd0);
        chk("flush_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        a_flush = 0;
        chk("flush_idle", {31'd0, a_busy}, 32'd0);
        issue(0, SZ_W, 0, 32'h40, 32'd0, 1, 32'd0, FLT_NONE);
        issue(0, SZ_W, 0, 32'h10, 32'd0, 1, 32'h1234_5678, FLT_NONE);
        drain();

        // Reset while a store is waiting
        issue(1, SZ_W, 0, 32'h80, 32'h55AA_55AA, 0, 32'd0, FLT_NONE);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_fault", {30'd0, a_fault}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        reset = 0;
        repeat (4) @(negedge clk);
        issue(0, SZ_W, 0, 32'h80, 32'd0, 1, 32'd0, FLT_NONE);
        issue(0, SZ_W, 0, 32'h10, 32'd0, 1, 32'd0, FLT_NONE);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
